random_draw_scheduler: RTL and testbench

Sequencer and arbiter for the shared N-bit LFSR random generator. It owns the generator's reset/seed pins, so it can seed from a free-running counter and discard warm-up outputs. It then shares the generator's output stream among NREQ game-logic requesters (spawners, item drops, AI) with round-robin grants. Each requester receives a value bounded by its own LIMIT. The block sits between the game FSMs and the single generator instance.

---
 rtl/random_draw_scheduler.sv | 131 +++++++++++++
 tb/tb_random_draw_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/random_draw_scheduler.sv
// rtl/random_draw_scheduler.sv - seeds, warms up and round-robin shares one LFSR among NREQ requesters
module random_draw_scheduler #(
    parameter int N         = 16,
    parameter int NREQ      = 4,
    parameter int WARMUP    = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic              GEN_RESET,
    output logic [N-1:0]      GEN_SEED,
    input  logic [N-1:0]      GEN_RESULT,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*N-1:0] LIMIT,
    output logic [NREQ-1:0]   ACK,
    output logic [N-1:0]      VALUE,
    output logic              BUSY
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {UNSEEDED, LOAD, WARM, READY, DRAW} state_t;

    state_t          state;
    logic [N-1:0]    seedcnt;
    logic [7:0]      warm_cnt;
    logic [3:0]      tries;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt;

    logic [N-1:0]    lim_arr [NREQ];
    logic [N-1:0]    limit_g;
    logic [N-1:0]    mask;
    logic [N-1:0]    sample;
    logic            accept;
    logic [PW-1:0]   pick;
    logic            pick_valid;
    logic [PW:0]     rr_sum;
    logic [PW-1:0]   rr_idx;
    logic [PW-1:0]   next_ptr;

    // First set request at or after ptr, wrapping.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        rr_sum     = '0;
        rr_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            rr_sum = {1'b0, ptr} + (PW+1)'(i);
            if (rr_sum >= (PW+1)'(NREQ))
                rr_sum = rr_sum - (PW+1)'(NREQ);
            rr_idx = rr_sum[PW-1:0];
            if (!pick_valid && REQ[rr_idx]) begin
                pick       = rr_idx;
                pick_valid = 1'b1;
            end
        end
    end

    // Smearing LIMIT-1 rightward yields the smallest 2^k-1 covering it; LIMIT=0 wraps to all ones.
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            lim_arr[i] = LIMIT[i*N +: N];
        limit_g = lim_arr[gnt];
        mask    = limit_g - N'(1);
        for (int s = 1; s < N; s = s * 2)
            mask = mask | (mask >> s);
        sample  = GEN_RESULT & mask;
        accept  = (limit_g == '0) || (sample < limit_g);
    end

    assign next_ptr = (gnt == PW'(NREQ-1)) ? '0 : gnt + PW'(1);
    assign BUSY     = (state != READY);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= UNSEEDED;
            seedcnt   <= '0;
            warm_cnt  <= '0;
            tries     <= '0;
            ptr       <= '0;
            gnt       <= '0;
            GEN_RESET <= 1'b0;
            GEN_SEED  <= '0;
            ACK       <= '0;
            VALUE     <= '0;
        end else begin
            seedcnt   <= seedcnt + N'(1);
            GEN_RESET <= 1'b0;
            ACK       <= '0;
            if (START) begin
                state     <= LOAD;
                GEN_RESET <= 1'b1;
                GEN_SEED  <= (seedcnt == '0) ? N'(1) : seedcnt;
            end else begin
                case (state)
                    UNSEEDED: state <= UNSEEDED;
                    LOAD: begin
                        state    <= WARM;
                        warm_cnt <= '0;
                    end
                    WARM: begin
                        if (warm_cnt == 8'(WARMUP-1))
                            state <= READY;
                        else
                            warm_cnt <= warm_cnt + 8'd1;
                    end
                    READY: begin
                        if (pick_valid) begin
                            gnt   <= pick;
                            tries <= '0;
                            state <= DRAW;
                        end
                    end
                    DRAW: begin
                        if (accept || tries == 4'(MAX_TRIES-1)) begin
                            // A rejected S is below 2*LIMIT, so S-LIMIT is a valid fallback.
                            VALUE <= accept ? sample : sample - limit_g;
                            ACK   <= {{(NREQ-1){1'b0}}, 1'b1} << gnt;
                            ptr   <= next_ptr;
                            state <= READY;
                        end else begin
                            tries <= tries + 4'd1;
                        end
                    end
                    default: state <= UNSEEDED;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_random_draw_scheduler.sv
// tb/tb_random_draw_scheduler.sv - self-checking bench for random_draw_scheduler
module tb_random_draw_scheduler;
    localparam int N = 16, NREQ = 4, WARMUP = 16, MAX_TRIES = 8;

    logic              CLK = 1'b0;
    logic              RESET, START, GEN_RESET, BUSY;
    logic [N-1:0]      GEN_SEED, GEN_RESULT, VALUE;
    logic [NREQ-1:0]   REQ, ACK;
    logic [NREQ*N-1:0] LIMIT;
    logic [N-1:0]      lfsr, stub_val;
    logic              stub_en;
    int                n_cmp = 0, n_err = 0;

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)          lfsr <= 16'h0001;
        else if (GEN_RESET) lfsr <= GEN_SEED;
        else                lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
    assign GEN_RESULT = stub_en ? stub_val : lfsr;

    random_draw_scheduler #(.N(N), .NREQ(NREQ), .WARMUP(WARMUP), .MAX_TRIES(MAX_TRIES)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .GEN_RESET(GEN_RESET), .GEN_SEED(GEN_SEED),
        .GEN_RESULT(GEN_RESULT), .REQ(REQ), .LIMIT(LIMIT), .ACK(ACK), .VALUE(VALUE), .BUSY(BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        chk("ack_with_busy", {31'b0, (ACK != '0) && BUSY}, 32'd0);
    endtask

    function automatic int mask_of(input int lim);
        int p;
        if (lim == 0) return (1 << N) - 1;
        p = 1;
        while (p < lim) p = p * 2;
        return p - 1;
    endfunction

    // One request on a single line while READY; reference decides per observed generator sample.
    task automatic do_draw(input int idx, input int lim, output int got_val, output int got_j);
        int  m, s, ev, samp;
        bit  hit, done;
        logic [31:0] lim_v;
        lim_v = lim;
        LIMIT[idx*N +: N] = lim_v[N-1:0];
        REQ[idx] = 1'b1;
        got_val = -1;
        got_j   = 0;
        step();
        chk("grant_no_ack", ACK, 32'd0);
        m = mask_of(lim);
        done = 0;
        for (int j = 1; j <= MAX_TRIES && !done; j++) begin
            samp = int'(GEN_RESULT);
            s    = samp & m;
            hit  = 0;
            ev   = 0;
            if (lim == 0 || s < lim) begin hit = 1; ev = s; end
            else if (j == MAX_TRIES) begin hit = 1; ev = s - lim; end
            step();
            if (hit) begin
                chk("ack_bit", ACK, 32'd1 << idx);
                chk("value", VALUE, ev);
                got_val = int'(VALUE);
                got_j   = j;
                REQ[idx] = 1'b0;
                done = 1;
            end else begin
                chk("ack_early", ACK, 32'd0);
            end
        end
        REQ[idx] = 1'b0;
    endtask

    initial begin
        int v, j, n, c, lim, idx;
        bit got;
        logic [NREQ-1:0] drop_mask;
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};

        RESET = 1'b1; START = 1'b1; REQ = '0; LIMIT = '0; stub_en = 1'b0; stub_val = '0;
        #1;
        chk("rst_gen_reset", GEN_RESET, 0);
        chk("rst_gen_seed", GEN_SEED, 0);
        chk("rst_ack", ACK, 0);
        chk("rst_value", VALUE, 0);
        chk("rst_busy", BUSY, 1);
        @(posedge CLK); #1;
        RESET = 1'b0;

        step();
        chk("load_gen_reset", GEN_RESET, 1);
        chk("load_seed", GEN_SEED, 32'h0001);
        chk("load_busy", BUSY, 1);
        START = 1'b0;
        step();
        chk("gen_reset_pulse", GEN_RESET, 0);
        for (int k = 2; k <= 16; k++) begin
            step();
            chk("warm_busy", BUSY, 1);
        end
        step();
        chk("ready_busy", BUSY, 0);

        // Round robin with all four requesters, dropping on ACK and re-raising a cycle later.
        LIMIT = '0;
        REQ = 4'b1111;
        drop_mask = '0;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            step();
            REQ = REQ | drop_mask;
            drop_mask = '0;
            if (ACK != '0) begin
                chk("rr_order", ACK, 32'd1 << exp_order[n]);
                drop_mask = ACK;
                REQ = REQ & ~ACK;
                n++;
            end
        end
        REQ = '0;
        chk("rr_count", n, 6);
        step();

        do_draw(0, 0, v, j);
        chk("lim0_latency", j, 1);
        for (int k = 0; k < 4; k++) begin
            do_draw(0, 1, v, j);
            chk("lim1_zero", v, 0);
        end

        stub_en = 1'b1;
        stub_val = 16'h00FF;
        do_draw(1, 100, v, j);
        chk("fallback_value", v, 27);
        chk("fallback_tries", j, 8);
        stub_val = 16'h0005;
        do_draw(2, 6, v, j);
        chk("stub5_value", v, 5);
        chk("stub5_tries", j, 1);
        stub_en = 1'b0;

        for (int k = 0; k < 500; k++) begin
            idx = int'($urandom_range(0, NREQ-1));
            do_draw(idx, 6, v, j);
            chk("bound6", {31'b0, v >= 0 && v <= 5}, 1);
        end
        for (int k = 0; k < 100; k++) begin
            idx = int'($urandom_range(0, NREQ-1));
            lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 65535));
            do_draw(idx, lim, v, j);
        end

        // START mid-draw: the pending request is served only after the new warm-up.
        stub_en = 1'b1;
        stub_val = 16'h00FF;
        LIMIT[1*N +: N] = 16'd100;
        REQ[1] = 1'b1;
        step();
        step();
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        chk("abort_no_ack", ACK, 0);
        chk("abort_gen_reset", GEN_RESET, 1);
        chk("abort_busy", BUSY, 1);
        got = 0;
        c = 0;
        while (c < 60 && !got) begin
            step();
            c++;
            if (ACK != '0) begin
                got = 1;
                chk("restart_ack", ACK, 32'd1 << 1);
                chk("restart_value", VALUE, 27);
            end
        end
        REQ[1] = 1'b0;
        chk("restart_got_ack", got, 1);
        chk("restart_latency", c, 26);
        stub_en = 1'b0;

        // Asynchronous reset in the middle of WARM.
        START = 1'b1;
        step();
        START = 1'b0;
        for (int k = 0; k < 5; k++) step();
        #3;
        RESET = 1'b1;
        #1;
        chk("mid_rst_gen_reset", GEN_RESET, 0);
        chk("mid_rst_gen_seed", GEN_SEED, 0);
        chk("mid_rst_ack", ACK, 0);
        chk("mid_rst_value", VALUE, 0);
        chk("mid_rst_busy", BUSY, 1);
        step();
        RESET = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
